memctrl: RTL and testbench
==========================

MEMCTRL -- requirements
Module: memctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: rdy  in  1  global pause; low freezes all registers.
REQ-004 SHALL have ports: enable_signal_from_lsu  in  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have ports: address_from_lsu  in  32  start byte address.
REQ-006 SHALL have ports: data_from_lsu  in  32  store data, little-endian.
REQ-007 SHALL have ports: read_or_write_flag_from_lsu  in  1  READ_FLAG/WRITE_FLAG.
REQ-008 SHALL have ports: size_from_lsu  in  3  bytes to move: 1, 2 or 4.
REQ-009 SHALL have ports: misbranch_flag  in  1  pipeline flush.
REQ-010 SHALL have ports: finish_flag_to_lsu  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: data_to_lsu  out  32  assembled load data, zero in unused upper bytes.
REQ-012 SHALL have ports: mem_din  in  8  RAM read byte; mem_dout  out  8  RAM write byte; mem_a  out  32  RAM byte address; mem_wr  out  1  1 = write.

Function
REQ-013 SHALL implement states IDLE, READ, WRITE, plus a 3-bit byte counter k.
REQ-014 IDLE + enable high SHALL latch address/data/size, drive mem_a=address, go READ or WRITE per flag; enable ignored in READ/WRITE.
REQ-015 RAM timing: byte for mem_a driven in cycle t SHALL be captured from mem_din in cycle t+1.
REQ-016 READ: mem_a SHALL step address+k for k=0..size-1 on consecutive cycles; byte k SHALL land in data_to_lsu[8k+7:8k].
REQ-017 READ: finish_flag_to_lsu SHALL be high in cycle size+1 after the accept cycle, with data_to_lsu complete in that same cycle; state returns IDLE at that edge.
REQ-018 WRITE: cycle k (k=0..size-1) SHALL drive mem_wr=1, mem_a=address+k, mem_dout=data[8k+7:8k]; finish_flag_to_lsu high in cycle size after accept; mem_wr=0 then.
REQ-019 mem_wr SHALL be 0 in IDLE and READ; mem_dout SHALL be 0 when mem_wr=0.
REQ-020 finish_flag_to_lsu SHALL be high exactly one enabled cycle per completed request.
REQ-021 misbranch_flag high in READ SHALL return IDLE at the next edge, no finish pulse, data_to_lsu unchanged.
REQ-022 misbranch_flag SHALL NOT affect WRITE (stores always complete) or IDLE acceptance.
REQ-023 A new request SHALL be accepted in the cycle finish_flag_to_lsu is high (back-to-back).
REQ-024 size values other than 1/2/4 SHALL be treated as 4.
REQ-025 Address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, k=0, finish_flag_to_lsu=0, data_to_lsu=0, mem_a=0, mem_dout=0, mem_wr=0, aborting any transfer including a store mid-write.
REQ-027 rst_n SHALL take priority over rdy.

Configuration
REQ-028 With MEMCTRL_IO_STALL_EN defined, SHALL add input io_buffer_full (1); a WRITE byte whose address has bits [17:16]=2'b11 SHALL stall (mem_wr=0, k held) while io_buffer_full is high, completion delayed accordingly.
REQ-029 Without MEMCTRL_IO_STALL_EN, io_buffer_full SHALL be absent and writes never stall.

Structure
REQ-030 READ_FLAG, WRITE_FLAG, ADDR_TYPE, DATA_TYPE and the memctrl state encodings SHALL live in shared constant.v.
REQ-031 SHALL be a single module, no sub-modules.

Verification
REQ-032 LW 0x100, RAM[0x100..0x103]=11,22,33,44 -> mem_a 0x100..0x103 on 4 cycles, finish in cycle 5 after accept, data_to_lsu=0x44332211.
REQ-033 SB addr 0x20 data 0xDEADBEEF -> one cycle mem_wr=1, mem_a=0x20, mem_dout=0xEF, finish next cycle, RAM[0x21] untouched.
REQ-034 LH 0x40 with misbranch_flag pulsed in READ cycle 1 -> IDLE next edge, no finish, no mem_wr.
REQ-035 SW 0x30000 data 0x41, io_buffer_full high 3 cycles (macro on) -> byte 0 write delayed 3 cycles, finish 7 cycles after accept.
REQ-036 rst_n low mid-SW after 2 bytes -> mem_wr=0 immediately, IDLE; LW accepted after release completes normally.
REQ-037 rdy low 2 cycles mid-LW -> all outputs frozen, finish delayed exactly 2 cycles, data correct.

Source files
------------

// File: rtl/memctrl_pkg.sv
// memctrl shared constants: LSU direction flags, bus types, FSM states.
// Also hosts the size normalisation used at request acceptance.
package memctrl_pkg;

  localparam logic READ_FLAG  = 1'b0;
  localparam logic WRITE_FLAG = 1'b1;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] DATA_TYPE;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_e;

  // Anything that is not a byte or halfword moves a full word.
  function automatic logic [2:0] norm_size(input logic [2:0] s);
    norm_size = (s == 3'd1 || s == 3'd2) ? s : 3'd4;
  endfunction

endpackage

// File: rtl/memctrl.sv
// memctrl: byte-serial bridge between the LSU and an 8-bit synchronous RAM.
// Define MEMCTRL_IO_STALL_EN to add io_buffer_full and hold I/O-space stores.
module memctrl
  import memctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        enable_signal_from_lsu,
  input  logic [31:0] address_from_lsu,
  input  logic [31:0] data_from_lsu,
  input  logic        read_or_write_flag_from_lsu,
  input  logic [2:0]  size_from_lsu,
  input  logic        misbranch_flag,
`ifdef MEMCTRL_IO_STALL_EN
  input  logic        io_buffer_full,
`endif
  output logic        finish_flag_to_lsu,
  output logic [31:0] data_to_lsu,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  state_e   state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [2:0] size_q, size_d;
  logic [2:0] size_in, k_nxt;
  ADDR_TYPE addr_q, addr_d, wr_a;
  DATA_TYPE wdata_q, wdata_d;
  DATA_TYPE buf_q, buf_d;
  DATA_TYPE data_q, data_d;
  logic     fin_q, fin_d;
  logic     accept, io_stall;
  logic [7:0] wbyte;

  assign size_in = norm_size(size_from_lsu);
  assign accept  = rst_n & rdy & enable_signal_from_lsu
                 & (state_q == IDLE);

  // Next read address; holds on the last byte while its data returns.
  assign k_nxt = (k_q + 3'd1 < size_q) ? k_q + 3'd1 : k_q;

  assign wr_a  = (state_q == WRITE) ? addr_q + {29'd0, k_q}
                                    : address_from_lsu;
  assign wbyte = (state_q == WRITE) ? wdata_q[{k_q[1:0], 3'b000} +: 8]
                                    : data_from_lsu[7:0];

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = io_buffer_full & (wr_a[17:16] == 2'b11);
`else
  assign io_stall = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    data_d   = data_q;
    fin_d    = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = address_from_lsu;
          wdata_d = data_from_lsu;
          size_d  = size_in;
          buf_d   = '0;
          k_d     = '0;
          mem_a   = wr_a;
          if (read_or_write_flag_from_lsu == READ_FLAG) begin
            state_d = READ;
          end else if (io_stall) begin
            state_d = WRITE;
          end else begin
            mem_wr   = 1'b1;
            mem_dout = wbyte;
            if (size_in == 3'd1) begin
              fin_d = 1'b1;
            end else begin
              state_d = WRITE;
              k_d     = 3'd1;
            end
          end
        end
      end
      READ: begin
        mem_a = addr_q + {29'd0, k_nxt};
        buf_d = buf_q | (DATA_TYPE'(mem_din) << {k_q, 3'b000});
        if (misbranch_flag) begin
          state_d = IDLE;
          k_d     = '0;
        end else if (k_q == size_q - 3'd1) begin
          data_d  = buf_d;
          fin_d   = 1'b1;
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      WRITE: begin
        mem_a = wr_a;
        if (!io_stall) begin
          mem_wr   = 1'b1;
          mem_dout = wbyte;
          if (k_q == size_q - 3'd1) begin
            fin_d   = 1'b1;
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A paused system must not see repeated strobes of a held store.
    if (!rdy) begin
      mem_wr   = 1'b0;
      mem_dout = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      fin_q   <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      k_q     <= k_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      fin_q   <= fin_d;
    end
  end

  assign finish_flag_to_lsu = fin_q;
  assign data_to_lsu        = data_q;

endmodule

// File: tb/tb_memctrl.sv
// Directed bench for memctrl against a 1 KiB byte RAM with one-cycle read latency.
// Build with MEMCTRL_IO_STALL_EN to include the I/O stall scenario.
module tb_memctrl;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rw;
  logic [2:0]  size;
  logic        mb;
  logic        io_full;
  logic        fin;
  logic [31:0] rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic        ld_en;
  logic [9:0]  ld_a;
  logic [7:0]  ld_d;
  logic [7:0]  ram [0:1023];

  int checks;
  int errors;

  memctrl dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .rdy                         (rdy),
    .enable_signal_from_lsu      (en),
    .address_from_lsu            (addr),
    .data_from_lsu               (wdata),
    .read_or_write_flag_from_lsu (rw),
    .size_from_lsu               (size),
    .misbranch_flag              (mb),
`ifdef MEMCTRL_IO_STALL_EN
    .io_buffer_full              (io_full),
`endif
    .finish_flag_to_lsu          (fin),
    .data_to_lsu                 (rdata),
    .mem_din                     (mem_din),
    .mem_dout                    (mem_dout),
    .mem_a                       (mem_a),
    .mem_wr                      (mem_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM pauses with the rest of the system; loader port is bench-only.
  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_a] <= ld_d;
    end else if (rdy) begin
      mem_din <= ram[mem_a[9:0]];
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    end
  end

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; en = 1'b1; rw = 1'b1;
    addr = 32'h1234; wdata = 32'h55AA55AA; size = 3'd4; mb = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL rst_fin got=%b exp=0", fin); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", rdata); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL rst_mem_a got=%h exp=0", mem_a); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr got=%b exp=0", mem_wr); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0", mem_dout); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    poke(10'h100, 8'h11); poke(10'h101, 8'h22);
    poke(10'h102, 8'h33); poke(10'h103, 8'h44);
    @(negedge clk);
    en = 1'b1; addr = 32'h100; rw = 1'b0; size = 3'd4;
    #1;
    checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL lw_a0 got=%h exp=100", mem_a); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL lw_wr0 got=%b exp=0", mem_wr); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      en = 1'b1; addr = 32'h200; rw = 1'b1;
      #1;
      checks++; if (mem_a !== 32'h100 + i) begin errors++; $display("FAIL lw_a%0d got=%h exp=%h", i, mem_a, 32'h100 + i); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL lw_wr%0d got=%b exp=0", i, mem_wr); end
      checks++; if (fin !== 1'b0) begin errors++; $display("FAIL lw_fin%0d got=%b exp=0", i, fin); end
    end
    @(negedge clk);
    en = 1'b0; rw = 1'b0;
    #1;
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL lw_fin4 got=%b exp=0", fin); end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL lw_fin5 got=%b exp=1", fin); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL lw_data got=%h exp=44332211", rdata); end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL lw_fin6 got=%b exp=0", fin); end
  endtask

  task automatic test_sb();
    poke(10'h021, 8'h77);
    @(negedge clk);
    en = 1'b1; addr = 32'h20; rw = 1'b1; size = 3'd1;
    wdata = 32'hDEADBEEF; mb = 1'b1;
    #1;
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL sb_wr got=%b exp=1", mem_wr); end
    checks++; if (mem_a !== 32'h20) begin errors++; $display("FAIL sb_a got=%h exp=20", mem_a); end
    checks++; if (mem_dout !== 8'hEF) begin errors++; $display("FAIL sb_dout got=%h exp=ef", mem_dout); end
    @(negedge clk);
    en = 1'b0; mb = 1'b0;
    #1;
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL sb_fin got=%b exp=1", fin); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL sb_wr1 got=%b exp=0", mem_wr); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL sb_dout1 got=%h exp=0", mem_dout); end
    @(negedge clk);
    en = 1'b1; addr = 32'h20; rw = 1'b0; size = 3'd2;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL sb_rb_fin got=%b exp=1", fin); end
    checks++; if (rdata !== 32'h000077EF) begin errors++; $display("FAIL sb_rb_data got=%h exp=000077ef", rdata); end
  endtask

  task automatic test_misbranch();
    poke(10'h040, 8'hAA); poke(10'h041, 8'hBB);
    @(negedge clk);
    en = 1'b1; addr = 32'h40; rw = 1'b0; size = 3'd2;
    @(negedge clk);
    en = 1'b0; mb = 1'b1;
    #1;
    checks++; if (mem_a !== 32'h41) begin errors++; $display("FAIL mb_a1 got=%h exp=41", mem_a); end
    @(negedge clk);
    mb = 1'b0;
    #1;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL mb_idle_a got=%h exp=0", mem_a); end
    for (int i = 2; i <= 4; i++) begin
      if (i > 2) begin @(negedge clk); #1; end
      checks++; if (fin !== 1'b0) begin errors++; $display("FAIL mb_fin%0d got=%b exp=0", i, fin); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL mb_wr%0d got=%b exp=0", i, mem_wr); end
      checks++; if (rdata !== 32'h000077EF) begin errors++; $display("FAIL mb_data%0d got=%h exp=000077ef", i, rdata); end
    end
  endtask

  task automatic test_rdy();
    @(negedge clk);
    en = 1'b1; addr = 32'h100; rw = 1'b0; size = 3'd4;
    @(negedge clk);
    en = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      rdy = 1'b0;
      #1;
      checks++; if (mem_a !== 32'h102) begin errors++; $display("FAIL rdy_a%0d got=%h exp=102", i, mem_a); end
      checks++; if (fin !== 1'b0) begin errors++; $display("FAIL rdy_fin%0d got=%b exp=0", i, fin); end
      checks++; if (rdata !== 32'h000077EF) begin errors++; $display("FAIL rdy_data%0d got=%h exp=000077ef", i, rdata); end
    end
    @(negedge clk);
    rdy = 1'b1;
    #1;
    checks++; if (mem_a !== 32'h102) begin errors++; $display("FAIL rdy_a4 got=%h exp=102", mem_a); end
    @(negedge clk); #1;
    checks++; if (mem_a !== 32'h103) begin errors++; $display("FAIL rdy_a5 got=%h exp=103", mem_a); end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL rdy_fin6 got=%b exp=0", fin); end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL rdy_fin7 got=%b exp=1", fin); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL rdy_data7 got=%h exp=44332211", rdata); end
  endtask

  task automatic test_store_misbranch();
    @(negedge clk);
    en = 1'b1; addr = 32'h50; rw = 1'b1; size = 3'd2;
    wdata = 32'h1234ABCD; mb = 1'b1;
    #1;
    checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h50 || mem_dout !== 8'hCD) begin
      errors++; $display("FAIL sh_b0 got=%b/%h/%h exp=1/50/cd", mem_wr, mem_a, mem_dout); end
    @(negedge clk);
    en = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h51 || mem_dout !== 8'hAB) begin
      errors++; $display("FAIL sh_b1 got=%b/%h/%h exp=1/51/ab", mem_wr, mem_a, mem_dout); end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b1 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL sh_fin got=%b/%b exp=1/0", fin, mem_wr); end
    mb = 1'b0;
  endtask

  task automatic test_back_to_back();
    poke(10'h3FF, 8'h99); poke(10'h000, 8'h88);
    @(negedge clk);
    en = 1'b1; addr = 32'h100; rw = 1'b0; size = 3'd1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; addr = 32'hFFFF_FFFF; size = 3'd2;
    #1;
    checks++; if (fin !== 1'b1 || rdata !== 32'h11) begin
      errors++; $display("FAIL b2b_lb got=%b/%h exp=1/00000011", fin, rdata); end
    checks++; if (mem_a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_a0 got=%h exp=ffffffff", mem_a); end
    @(negedge clk);
    en = 1'b0;
    #1;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL wrap_a1 got=%h exp=0", mem_a); end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL wrap_fin4 got=%b exp=0", fin); end
    @(negedge clk);
    en = 1'b1; addr = 32'h100; size = 3'd3;
    #1;
    checks++; if (fin !== 1'b1 || rdata !== 32'h8899) begin
      errors++; $display("FAIL wrap_data got=%b/%h exp=1/00008899", fin, rdata); end
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL sz3_fin4 got=%b exp=0", fin); end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b1 || rdata !== 32'h44332211) begin
      errors++; $display("FAIL sz3_data got=%b/%h exp=1/44332211", fin, rdata); end
  endtask

  task automatic test_reset_mid_write();
    poke(10'h062, 8'h5A); poke(10'h063, 8'hA5);
    @(negedge clk);
    en = 1'b1; addr = 32'h60; rw = 1'b1; size = 3'd4; wdata = 32'hCAFEF00D;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
      errors++; $display("FAIL rstw_bus got=%b/%h/%h exp=0/0/0", mem_wr, mem_a, mem_dout); end
    checks++; if (fin !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL rstw_out got=%b/%h exp=0/0", fin, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1; addr = 32'h60; rw = 1'b0; size = 3'd4;
    #1;
    checks++; if (mem_a !== 32'h60 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL rstw_acc got=%h/%b exp=60/0", mem_a, mem_wr); end
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (fin !== 1'b1 || rdata !== 32'hA55AF00D) begin
      errors++; $display("FAIL rstw_lw got=%b/%h exp=1/a55af00d", fin, rdata); end
  endtask

`ifdef MEMCTRL_IO_STALL_EN
  task automatic test_io_stall();
    @(negedge clk);
    en = 1'b1; addr = 32'h30000; rw = 1'b1; size = 3'd4;
    wdata = 32'h41; io_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); en = 1'b0; end
      #1;
      checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h30000) begin
        errors++; $display("FAIL io_stall%0d got=%b/%h exp=0/30000", i, mem_wr, mem_a); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io_full = 1'b0;
      #1;
      checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 + i || mem_dout !== ((i == 0) ? 8'h41 : 8'h00)) begin
        errors++; $display("FAIL io_wr%0d got=%b/%h/%h", i, mem_wr, mem_a, mem_dout); end
      checks++; if (fin !== 1'b0) begin errors++; $display("FAIL io_fin%0d got=%b exp=0", i + 3, fin); end
    end
    @(negedge clk); #1;
    checks++; if (fin !== 1'b1 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL io_fin7 got=%b/%b exp=1/0", fin, mem_wr); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0; io_full = 1'b0;
    test_reset();
    test_lw();
    test_sb();
    test_misbranch();
    test_rdy();
    test_store_misbranch();
    test_back_to_back();
    test_reset_mid_write();
`ifdef MEMCTRL_IO_STALL_EN
    test_io_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
